mcycle_unit: RTL and testbench
==============================

# mcycle_unit

Iterative 32-bit multiply/divide execution unit that produces the `Busy` stall signal consumed by the program counter (`M_Busy`). While an operation is in flight, the unit holds `Busy` high so the PC and the rest of the datapath freeze on the current instruction. When the result is ready, `Busy` drops for exactly one cycle so the PC advances past the instruction. It sits beside the ALU in the execute stage, and its results are muxed into the write-back path.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; fixed at 32 for this core.

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request from decoder; held high for the whole instruction.
- `MCycleOp`  in  2  bit0: 0 = multiply, 1 = divide; bit1: 0 = unsigned, 1 = signed.
- `Operand1`  in  32  multiplicand / dividend.
- `Operand2`  in  32  multiplier / divisor.
- `Result1`  out  32  multiply: product[31:0]; divide: quotient.
- `Result2`  out  32  multiply: product[63:32]; divide: remainder.
- `Busy`  out  1  stall request to the PC and register file.

## Operation
- States: IDLE, COMPUTING, DONE.
- IDLE:
  - `Busy = Start`, combinational, so the PC stalls in the request cycle itself.
  - When `Start` is high: latch `MCycleOp`, latch the operands, clear the 6-bit counter, and go to COMPUTING.
  - For signed ops, latch the operand magnitudes and record their signs.
- COMPUTING:
  - `Busy = 1` throughout.
  - One iteration per cycle; the counter increments each cycle.
  - On the cycle with counter = 31, write the final results and go to DONE.
- Multiply:
  - Shift-add on the 64-bit accumulator {hi, lo}, one multiplier bit per cycle, LSB first.
  - Signed: negate the 64-bit magnitude product when the operand signs differ.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle, MSB first.
  - Signed: negate the quotient when the operand signs differ; the remainder takes the sign of the dividend.
- Divide by zero (signed or unsigned):
  - `Result1` = 32'hFFFF_FFFF.
  - `Result2` = `Operand1` as originally presented.
- Signed overflow, 32'h8000_0000 / 32'hFFFF_FFFF:
  - `Result1` = 32'h8000_0000.
  - `Result2` = 0.
  - The magnitude path must produce this result naturally; no wrap error is allowed.
- DONE:
  - `Busy = 0` for exactly one cycle and `Start` is ignored, because the same instruction is still presenting it.
  - Unconditionally return to IDLE.
- Results are registered and held until the next accepted `Start` completes; they never change during COMPUTING.
- Operand or `MCycleOp` changes during COMPUTING are ignored (the latched copies are used).

## Timing
- Reset, synchronous (takes effect on the rising edge while `Reset` is high):
  - State = IDLE, counter = 0, `Result1` = `Result2` = 0.
  - `Busy` is combinational, so it equals `Start` during the Reset cycle.
  - Reset mid-COMPUTING aborts the operation, and the results read 0 after that edge.
- Latency:
  - `Start` is sampled in IDLE at cycle 0.
  - Cycles 0–32 have `Busy` = 1 (33 cycles total).
  - Cycle 33 is DONE: `Busy` = 0 and the results are valid.
  - The PC advances on the rising edge that ends cycle 33.
- Back-to-back: a `Start` in the cycle after DONE (IDLE) is accepted immediately. Minimum spacing between operations is 34 cycles.
- `Start` low in IDLE: `Busy` = 0, no state change, results held.

## Configuration
- `MCYCLE_DIV_EN`:
  - Defined: divider datapath compiled in; divide behaves as described above.
  - Undefined: the divider logic is removed. A divide request (`MCycleOp[0]` = 1) goes IDLE → DONE directly, so `Busy` is high only in the request cycle. It writes `Result1` = `Result2` = 0.
  - Multiply behaviour is identical in both builds.

## Test plan
- Reset then idle: `Start` = 0 for 5 cycles → `Busy` = 0, `Result1` = `Result2` = 0.
- Unsigned multiply 32'hFFFF_FFFF × 32'h0000_0002, `Start` held until `Busy` falls → `Busy` high for 33 cycles; in DONE, `Result2` = 32'h1, `Result1` = 32'hFFFF_FFFE; one DONE cycle, then IDLE.
- Signed multiply −7 × 3 → {`Result2`, `Result1`} = 64'hFFFF_FFFF_FFFF_FFEB. Signed divide −7 / 2 → `Result1` = 32'hFFFF_FFFD, `Result2` = 32'hFFFF_FFFF.
- Unsigned divide 100 / 0 → `Result1` = 32'hFFFF_FFFF, `Result2` = 100. Signed 32'h8000_0000 / −1 → `Result1` = 32'h8000_0000, `Result2` = 0.
- Assert `Reset` at cycle 10 of a multiply → `Busy` follows `Start`, results 0; `Start` still high restarts the operation, and completion is exactly 33 cycles after `Reset` deasserts.
- Build without `MCYCLE_DIV_EN`: divide 9 / 3 → `Busy` high for 1 cycle, results 0; multiply 6 × 7 → `Result1` = 42 after 33 busy cycles.

Source files
------------

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative 32-bit multiply/divide unit for the execute stage.
// Drives Busy to stall the PC while an operation is in flight; Busy drops
// for exactly one cycle (DONE) when results are ready.
// Optional feature macro: MCYCLE_DIV_EN (defined = restoring divider present;
// undefined = divide requests complete immediately with zero results).
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [5:0]       r_cnt;
  logic             r_neg_q;   // negate product / quotient at the end
  logic [WIDTH-1:0] r_hi;      // multiply: accumulator high; divide: partial remainder
  logic [WIDTH-1:0] r_lo;      // multiply: multiplier/low product; divide: dividend/quotient
  logic [WIDTH-1:0] r_b;       // multiply: multiplicand magnitude; divide: divisor magnitude
  logic [WIDTH-1:0] r_res1;
  logic [WIDTH-1:0] r_res2;
`ifdef MCYCLE_DIV_EN
  logic             r_is_div;
  logic             r_neg_r;   // remainder follows dividend sign
  logic             r_div0;
  logic [WIDTH-1:0] r_orig1;   // dividend as presented, returned on divide by zero
`endif

  // Operand sign extraction and magnitudes (unsigned ops use raw values)
  logic             w_s1, w_s2;
  logic [WIDTH-1:0] w_mag1, w_mag2;
  assign w_s1   = MCycleOp[1] & Operand1[WIDTH-1];
  assign w_s2   = MCycleOp[1] & Operand2[WIDTH-1];
  assign w_mag1 = w_s1 ? -Operand1 : Operand1;
  assign w_mag2 = w_s2 ? -Operand2 : Operand2;

  // One shift-add multiply step, LSB of multiplier first
  logic [WIDTH:0]     w_msum;
  logic [WIDTH-1:0]   w_mul_hi, w_mul_lo;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  assign w_msum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
  assign w_mul_hi = w_msum[WIDTH:1];
  assign w_mul_lo = {w_msum[0], r_lo[WIDTH-1:1]};
  assign w_prod   = {w_mul_hi, w_mul_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

`ifdef MCYCLE_DIV_EN
  // One restoring-division step, MSB of dividend first.
  // The partial remainder stays below the divisor, so a 33-bit trial
  // subtraction is enough and bit WIDTH is the borrow.
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_hi, w_div_lo, w_quo, w_rem;
  assign w_trial  = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
  assign w_ge     = ~w_trial[WIDTH];
  assign w_div_hi = w_ge ? w_trial[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};
  assign w_quo    = r_neg_q ? -w_div_lo : w_div_lo;
  assign w_rem    = r_neg_r ? -w_div_hi : w_div_hi;
`endif

  // Next iteration values and final results for the last iteration
  logic [WIDTH-1:0] w_nhi, w_nlo, w_fin1, w_fin2;
  always_comb begin
    w_nhi  = w_mul_hi;
    w_nlo  = w_mul_lo;
    w_fin1 = w_prod_s[WIDTH-1:0];
    w_fin2 = w_prod_s[2*WIDTH-1:WIDTH];
`ifdef MCYCLE_DIV_EN
    if (r_is_div) begin
      w_nhi = w_div_hi;
      w_nlo = w_div_lo;
      if (r_div0) begin
        w_fin1 = '1;
        w_fin2 = r_orig1;
      end else begin
        w_fin1 = w_quo;
        w_fin2 = w_rem;
      end
    end
`endif
  end

  // Stall request: follows Start in IDLE so the PC freezes in the request cycle
  always_comb begin
    Busy = 1'b0;
    case (r_state)
      S_IDLE:  Busy = Start;
      S_COMP:  Busy = 1'b1;
      default: Busy = 1'b0;
    endcase
  end

  // Control FSM, iteration datapath and result registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_res1  <= '0;
      r_res2  <= '0;
`ifdef MCYCLE_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_orig1  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cnt   <= '0;
            r_neg_q <= w_s1 ^ w_s2;
            r_hi    <= '0;
            r_lo    <= MCycleOp[0] ? w_mag1 : w_mag2;
            r_b     <= MCycleOp[0] ? w_mag2 : w_mag1;
`ifdef MCYCLE_DIV_EN
            r_is_div <= MCycleOp[0];
            r_neg_r  <= w_s1;
            r_div0   <= (Operand2 == '0);
            r_orig1  <= Operand1;
            r_state  <= S_COMP;
`else
            if (MCycleOp[0]) begin
              r_res1  <= '0;
              r_res2  <= '0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_COMP;
            end
`endif
          end
        end
        S_COMP: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_ITER) begin
            r_res1  <= w_fin1;
            r_res2  <= w_fin2;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Result1 = r_res1;
  assign Result2 = r_res2;

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: stimulus pushes expected results and
// busy-cycle counts; a monitor pops and compares on every Busy falling edge.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        Reset, Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1, Operand2, Result1, Result2;
  logic        Busy;

  always #5 CLK = ~CLK;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    int          busy;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    int          busy;
    bit          keep;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          total = 0;
  int          bad   = 0;
  bit          chain = 1'b0;
  logic [31:0] last_r1 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every Busy 1->0 transition outside reset is a completed operation
  initial begin
    int   bcnt;
    logic pb;
    exp_t e;
    bcnt = 0;
    pb   = 1'b0;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        bcnt = 0;
        pb   = 1'b0;
      end else if (Busy) begin
        bcnt++;
        pb = 1'b1;
      end else begin
        if (pb) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got r1=%h r2=%h want none", Result1, Result2);
          end else begin
            e = sb.pop_front();
            check("result1", Result1, e.r1);
            check("result2", Result2, e.r2);
            check("busy_cycles", bcnt, e.busy);
          end
        end
        bcnt = 0;
        pb   = 1'b0;
      end
    end
  end

  task automatic run_op(input vec_t v);
    int   n;
    exp_t e;
    if (!chain) begin
      @(posedge CLK);
      #1;
    end
    e.r1 = v.r1; e.r2 = v.r2; e.busy = v.busy;
    sb.push_back(e);
    MCycleOp = v.op; Operand1 = v.a; Operand2 = v.b; Start = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (!Busy) break;
      if (n == 2) begin
        check("hold_during_compute", Result1, last_r1);
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = ~v.op;
      end
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL timeout: busy never fell, got %0d cycles want %0d", n, v.busy);
    end
    last_r1 = v.r1;
    chain   = v.keep;
    if (!v.keep) begin
      @(posedge CLK);
      #1;
      Start = 1'b0;
      @(negedge CLK);
      check("idle_busy_after_done", Busy, 0);
      check("hold_after_done", Result1, v.r1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    exp_t e;
    Reset = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      check("reset_idle_busy", Busy, 0);
    end
    check("reset_r1", Result1, 0);
    check("reset_r2", Result2, 0);

    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b1});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 33, 1'b1});
    vecs.push_back('{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFB, 32'h0000_0028, 32'h0000_0000, 33, 1'b0});
    vecs.push_back('{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 33, 1'b0});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 33, 1'b0});
`ifdef MCYCLE_DIV_EN
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0});
    vecs.push_back('{2'b01, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0064, 33, 1'b1});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33, 1'b0});
    vecs.push_back('{2'b01, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 33, 1'b0});
    vecs.push_back('{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 33, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 33, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0});
`else
    vecs.push_back('{2'b01, 32'h0000_0009, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FFF7, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1, 1'b1});
`endif
    vecs.push_back('{2'b00, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 32'h0000_0000, 33, 1'b0});

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset in the middle of a multiply; Start stays high and restarts it
    @(posedge CLK);
    #1;
    e.r1 = 32'd42; e.r2 = 32'd0; e.busy = 33;
    sb.push_back(e);
    MCycleOp = 2'b00; Operand1 = 32'd6; Operand2 = 32'd7; Start = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("hold_before_reset", Result1, last_r1);
    repeat (5) @(posedge CLK);
    #1 Reset = 1'b1;
    @(negedge CLK);
    check("busy_follows_start_in_reset", Busy, 1);
    @(posedge CLK);
    #1 Reset = 1'b0;
    check("midreset_r1", Result1, 0);
    check("midreset_r2", Result2, 0);
    for (n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (!Busy) break;
    end
    check("restart_latency", n, 33);
    @(posedge CLK);
    #1 Start = 1'b0;

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
